// File: rtl/pipeline_issue_sequencer_pkg.sv
// Shared opcode encodings, instruction field positions and FSM state type
// for the front-end issue sequencer.
package pipeline_issue_sequencer_pkg;

    localparam int INS_W = 24;

    localparam logic [4:0] OP_LD      = 5'b10100;
    localparam logic [4:0] OP_ST      = 5'b10101;
    localparam logic [4:0] OP_JMP     = 5'b11000;
    localparam logic [2:0] OP_CJ_PFX  = 3'b111;
    localparam logic [1:0] OP_IMM_PFX = 2'b01;

    localparam logic [INS_W-1:0] NOP = 24'h000000;

    localparam int OPC_HI  = 23;
    localparam int OPC_LO  = 19;
    localparam int DST_HI  = 18;
    localparam int DST_LO  = 14;
    localparam int SRCA_HI = 13;
    localparam int SRCA_LO = 9;
    localparam int SRCB_HI = 8;
    localparam int SRCB_LO = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LD_STALL = 2'd2,
        ST_BR_WAIT  = 2'd3
    } state_t;

    function automatic logic is_cj(input logic [4:0] op);
        return op[4:2] == OP_CJ_PFX;
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return op[4:3] == OP_IMM_PFX;
    endfunction

endpackage

// File: rtl/pipeline_issue_sequencer_hazard_detect.sv
// Load-use hazard check: flags when the instruction at the fetch PC reads the
// destination of a load issued in the previous cycle. Purely combinational.
module issue_hazard_detect
    import pipeline_issue_sequencer_pkg::*;
(
    input  logic [4:0] i_prev_op,
    input  logic [4:0] i_prev_dest,
    input  logic       i_prev_vld,
    input  logic [4:0] i_op,
    input  logic [4:0] i_src_a,
    input  logic [4:0] i_src_b,
    output logic       o_hazard
);

    logic w_prev_ld;
    logic w_reads_b;

    assign w_prev_ld = i_prev_vld && (i_prev_op == OP_LD);
    // Immediate forms and JMP reuse the srcB bits for immediate/target data.
    assign w_reads_b = !is_imm(i_op) && (i_op != OP_JMP);

    assign o_hazard = w_prev_ld &&
                      ((i_src_a == i_prev_dest) ||
                       (w_reads_b && (i_src_b == i_prev_dest)));

endmodule

// File: rtl/pipeline_issue_sequencer.sv
// Front-end issue sequencer: owns the PC, issues one instruction per cycle,
// bubbles on load-use hazards and sequences unconditional/conditional jumps.
module pipeline_issue_sequencer
    import pipeline_issue_sequencer_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int COND_LAT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic [23:0]      i_ins_mem,
    input  logic             i_cond_taken,
    output logic [PC_W-1:0]  o_pc,
    output logic [23:0]      o_ins_issue,
    output logic             o_issue_valid,
    output logic             o_stall,
    output logic [1:0]       o_state
);

    localparam int CNT_W = 3;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [23:0]       r_ins_issue;
    logic              r_issue_valid;
    logic              r_stall;
    logic [CNT_W-1:0]  r_cnt;
    logic [PC_W-1:0]   r_br_target;

    logic [4:0]        w_op;
    logic [PC_W-1:0]   w_target;
    logic [PC_W-1:0]   w_pc_inc;
    logic              w_is_jmp;
    logic              w_is_cj;
    logic              w_hazard;

    assign w_op     = i_ins_mem[OPC_HI:OPC_LO];
    assign w_target = i_ins_mem[PC_W:1];
    assign w_pc_inc = r_pc + 1'b1;
    assign w_is_jmp = (w_op == OP_JMP);
    assign w_is_cj  = is_cj(w_op);

    issue_hazard_detect u_hazard (
        .i_prev_op   (r_ins_issue[OPC_HI:OPC_LO]),
        .i_prev_dest (r_ins_issue[DST_HI:DST_LO]),
        .i_prev_vld  (r_issue_valid),
        .i_op        (w_op),
        .i_src_a     (i_ins_mem[SRCA_HI:SRCA_LO]),
        .i_src_b     (i_ins_mem[SRCB_HI:SRCB_LO]),
        .o_hazard    (w_hazard)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_ins_issue   <= NOP;
            r_issue_valid <= 1'b0;
            r_stall       <= 1'b0;
            r_cnt         <= '0;
            r_br_target   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ins_issue   <= NOP;
                    r_issue_valid <= 1'b0;
                    r_stall       <= 1'b0;
                    if (i_run) begin
                        r_state <= ST_RUN;
                    end
                end

                // LD_STALL re-issues the held instruction through the same
                // decode as RUN; run=0 is only honoured once back in RUN.
                ST_RUN, ST_LD_STALL: begin
                    if ((r_state == ST_RUN) && !i_run) begin
                        r_ins_issue   <= NOP;
                        r_issue_valid <= 1'b0;
                        r_stall       <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if ((r_state == ST_RUN) && w_hazard) begin
                        r_ins_issue   <= NOP;
                        r_issue_valid <= 1'b0;
                        r_stall       <= 1'b1;
                        r_state       <= ST_LD_STALL;
                    end else begin
                        r_ins_issue   <= i_ins_mem;
                        r_issue_valid <= 1'b1;
                        r_stall       <= 1'b0;
                        r_state       <= ST_RUN;
                        if (w_is_jmp) begin
                            r_pc <= w_target;
                        end else if (w_is_cj) begin
                            r_cnt       <= CNT_W'(COND_LAT);
                            r_br_target <= w_target;
                            r_state     <= ST_BR_WAIT;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end

                ST_BR_WAIT: begin
                    r_ins_issue   <= NOP;
                    r_issue_valid <= 1'b0;
                    r_stall       <= 1'b1;
                    r_cnt         <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_pc    <= i_cond_taken ? r_br_target : w_pc_inc;
                        r_state <= i_run ? ST_RUN : ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_ins_issue   = r_ins_issue;
    assign o_issue_valid = r_issue_valid;
    assign o_stall       = r_stall;
    assign o_state       = r_state;

endmodule

// File: tb/tb_pipeline_issue_sequencer.sv
// Directed bench for pipeline_issue_sequencer: combinational instruction
// memory model, hand-computed expectations checked with immediate assertions.
module tb_pipeline_issue_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_run;
    logic [23:0] i_ins_mem;
    logic        i_cond_taken;
    logic [7:0]  o_pc;
    logic [23:0] o_ins_issue;
    logic        o_issue_valid;
    logic        o_stall;
    logic [1:0]  o_state;

    logic [23:0] mem [256];

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_LDST = 2'd2, S_BRW = 2'd3;

    pipeline_issue_sequencer #(.PC_W(8), .COND_LAT(2)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_run         (i_run),
        .i_ins_mem     (i_ins_mem),
        .i_cond_taken  (i_cond_taken),
        .o_pc          (o_pc),
        .o_ins_issue   (o_ins_issue),
        .o_issue_valid (o_issue_valid),
        .o_stall       (o_stall),
        .o_state       (o_state)
    );

    always #5 i_clk = ~i_clk;

    assign i_ins_mem = mem[o_pc];

    function automatic logic [23:0] enc(input logic [4:0] op, input logic [4:0] d,
                                        input logic [4:0] a, input logic [4:0] b);
        return {op, d, a, b, 4'h0};
    endfunction

    function automatic logic [23:0] encj(input logic [4:0] op, input logic [7:0] t);
        return {op, 5'd0, 5'd0, t, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 24'h0;
        for (int i = 0; i < 4; i++) mem[i] = enc(5'b00001, 5'(i + 1), 5'd10, 5'd11);
        mem[4]     = enc(5'b10100, 5'd5, 5'd12, 5'd0);     // LD r5
        mem[5]     = enc(5'b00001, 5'd6, 5'd13, 5'd5);     // ALU reads r5 on srcB
        mem[6]     = enc(5'b00001, 5'd7, 5'd14, 5'd15);
        mem[7]     = encj(5'b11000, 8'h40);
        mem[8'h40] = encj(5'b11000, 8'h09);
        mem[9]     = encj(5'b11100, 8'h10);
        mem[8'h10] = encj(5'b11000, 8'h09);
        mem[8'h0A] = encj(5'b11101, 8'h20);
        mem[8'h20] = encj(5'b11000, 8'hFF);
        mem[8'hFF] = enc(5'b00010, 5'd9, 5'd16, 5'd17);

        i_rst_n = 1'b0;
        i_run = 1'b0;
        i_cond_taken = 1'b0;
        step();
        step();
        chk("rst_pc", 32'(o_pc), 32'h0);
        chk("rst_ins", 32'(o_ins_issue), 32'h0);
        chk("rst_valid", 32'(o_issue_valid), 32'h0);
        chk("rst_stall", 32'(o_stall), 32'h0);
        chk("rst_state", 32'(o_state), 32'(S_IDLE));

        // 1: release with run=1; transition cycle issues nothing
        i_rst_n = 1'b1;
        i_run = 1'b1;
        step();
        chk("t1_state_run", 32'(o_state), 32'(S_RUN));
        chk("t1_valid0", 32'(o_issue_valid), 32'h0);
        chk("t1_pc0", 32'(o_pc), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t1_ins%0d", i), 32'(o_ins_issue), 32'(enc(5'b00001, 5'(i + 1), 5'd10, 5'd11)));
            chk($sformatf("t1_pc%0d", i + 1), 32'(o_pc), 32'(i + 1));
            chk($sformatf("t1_valid%0d", i), 32'(o_issue_valid), 32'h1);
        end

        // 2: LD r5 then consumer -> one bubble
        step();
        chk("t2_ld_issue", 32'(o_ins_issue), 32'(enc(5'b10100, 5'd5, 5'd12, 5'd0)));
        chk("t2_ld_pc", 32'(o_pc), 32'h5);
        step();
        chk("t2_bub_ins", 32'(o_ins_issue), 32'h0);
        chk("t2_bub_valid", 32'(o_issue_valid), 32'h0);
        chk("t2_bub_stall", 32'(o_stall), 32'h1);
        chk("t2_bub_pc", 32'(o_pc), 32'h5);
        chk("t2_bub_state", 32'(o_state), 32'(S_LDST));
        step();
        chk("t2_use_ins", 32'(o_ins_issue), 32'(enc(5'b00001, 5'd6, 5'd13, 5'd5)));
        chk("t2_use_stall", 32'(o_stall), 32'h0);
        chk("t2_use_pc", 32'(o_pc), 32'h6);
        chk("t2_use_state", 32'(o_state), 32'(S_RUN));
        step();
        chk("t2_pc7", 32'(o_pc), 32'h7);

        // 3: JMP to 0x40, no bubble
        step();
        chk("t3_jmp_ins", 32'(o_ins_issue), 32'(encj(5'b11000, 8'h40)));
        chk("t3_jmp_pc", 32'(o_pc), 32'h40);
        chk("t3_jmp_valid", 32'(o_issue_valid), 32'h1);
        step();
        chk("t3_jmp2_pc", 32'(o_pc), 32'h09);
        chk("t3_jmp2_valid", 32'(o_issue_valid), 32'h1);

        // 4a: CJ taken; memory at pc altered mid-wait to prove target is held
        step();
        chk("t4_cj_ins", 32'(o_ins_issue), 32'(encj(5'b11100, 8'h10)));
        chk("t4_cj_state", 32'(o_state), 32'(S_BRW));
        chk("t4_cj_pc", 32'(o_pc), 32'h09);
        chk("t4_cj_stall", 32'(o_stall), 32'h0);
        i_cond_taken = 1'b0;
        step();
        chk("t4_w1_ins", 32'(o_ins_issue), 32'h0);
        chk("t4_w1_stall", 32'(o_stall), 32'h1);
        chk("t4_w1_pc", 32'(o_pc), 32'h09);
        chk("t4_w1_state", 32'(o_state), 32'(S_BRW));
        mem[9] = enc(5'b00001, 5'd1, 5'd2, 5'd3);
        i_cond_taken = 1'b1;
        step();
        chk("t4_w2_ins", 32'(o_ins_issue), 32'h0);
        chk("t4_w2_stall", 32'(o_stall), 32'h1);
        chk("t4_taken_pc", 32'(o_pc), 32'h10);
        chk("t4_taken_state", 32'(o_state), 32'(S_RUN));
        mem[9] = encj(5'b11100, 8'h10);
        i_cond_taken = 1'b0;
        step();
        chk("t4_back_pc", 32'(o_pc), 32'h09);
        chk("t4_back_stall", 32'(o_stall), 32'h0);

        // 4b: CJ not taken (cond high only on the first wait cycle)
        step();
        chk("t4b_cj_state", 32'(o_state), 32'(S_BRW));
        i_cond_taken = 1'b1;
        step();
        chk("t4b_w1_pc", 32'(o_pc), 32'h09);
        i_cond_taken = 1'b0;
        step();
        chk("t4b_nt_pc", 32'(o_pc), 32'h0A);
        chk("t4b_nt_state", 32'(o_state), 32'(S_RUN));

        // 6: run dropped in BR_WAIT -> branch completes, then IDLE
        step();
        chk("t6_cj_state", 32'(o_state), 32'(S_BRW));
        i_run = 1'b0;
        i_cond_taken = 1'b1;
        step();
        chk("t6_w1_state", 32'(o_state), 32'(S_BRW));
        step();
        chk("t6_pc", 32'(o_pc), 32'h20);
        chk("t6_idle", 32'(o_state), 32'(S_IDLE));
        i_cond_taken = 1'b0;
        mem[0] = encj(5'b11100, 8'h30);
        step();
        step();
        chk("t6_held_pc", 32'(o_pc), 32'h20);
        chk("t6_held_valid", 32'(o_issue_valid), 32'h0);
        chk("t6_held_state", 32'(o_state), 32'(S_IDLE));
        i_run = 1'b1;
        step();
        chk("t6_rerun_state", 32'(o_state), 32'(S_RUN));
        chk("t6_rerun_pc", 32'(o_pc), 32'h20);

        // 5: wrap at 0xFF, then async reset mid-BR_WAIT
        step();
        chk("t5_pc_ff", 32'(o_pc), 32'hFF);
        step();
        chk("t5_wrap_pc", 32'(o_pc), 32'h00);
        chk("t5_wrap_ins", 32'(o_ins_issue), 32'(enc(5'b00010, 5'd9, 5'd16, 5'd17)));
        step();
        chk("t5_cj_state", 32'(o_state), 32'(S_BRW));
        step();
        chk("t5_w1_stall", 32'(o_stall), 32'h1);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("t5_arst_pc", 32'(o_pc), 32'h0);
        chk("t5_arst_state", 32'(o_state), 32'(S_IDLE));
        chk("t5_arst_stall", 32'(o_stall), 32'h0);
        chk("t5_arst_valid", 32'(o_issue_valid), 32'h0);
        i_run = 1'b0;
        i_cond_taken = 1'b1;
        step();
        i_rst_n = 1'b1;
        step();
        step();
        chk("t5_post_pc", 32'(o_pc), 32'h0);
        chk("t5_post_state", 32'(o_state), 32'(S_IDLE));

        // Extra hazard classes: D==0, IMM ignores srcB, ST reads srcB, JMP reads srcA
        mem[0] = enc(5'b10100, 5'd0, 5'd1, 5'd2);
        mem[1] = enc(5'b01000, 5'd4, 5'd7, 5'd0);
        mem[2] = enc(5'b10100, 5'd3, 5'd8, 5'd9);
        mem[3] = enc(5'b10101, 5'd0, 5'd10, 5'd3);
        mem[4] = enc(5'b10100, 5'd0, 5'd11, 5'd12);
        mem[5] = encj(5'b11000, 8'h50);
        i_cond_taken = 1'b0;
        i_run = 1'b1;
        step();
        step();
        chk("h_ld0_pc", 32'(o_pc), 32'h1);
        step();
        chk("h_imm_nostall", 32'(o_stall), 32'h0);
        chk("h_imm_ins", 32'(o_ins_issue), 32'(enc(5'b01000, 5'd4, 5'd7, 5'd0)));
        chk("h_imm_pc", 32'(o_pc), 32'h2);
        step();
        step();
        chk("h_st_stall", 32'(o_stall), 32'h1);
        chk("h_st_pc", 32'(o_pc), 32'h3);
        step();
        chk("h_st_ins", 32'(o_ins_issue), 32'(enc(5'b10101, 5'd0, 5'd10, 5'd3)));
        chk("h_st_pc4", 32'(o_pc), 32'h4);
        step();
        step();
        chk("h_jmp_stall", 32'(o_stall), 32'h1);
        chk("h_jmp_hold_pc", 32'(o_pc), 32'h5);
        step();
        chk("h_jmp_ins", 32'(o_ins_issue), 32'(encj(5'b11000, 8'h50)));
        chk("h_jmp_pc", 32'(o_pc), 32'h50);
        chk("h_jmp_state", 32'(o_state), 32'(S_RUN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
